// File: rtl/stage_fetch_queue_pkg.sv
// stage_fetch_queue_pkg: shared word type, NOP encoding and queue entry layout for the fetch stage
package stage_fetch_queue_pkg;
  typedef logic [31:0] word_t;
  localparam word_t NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    word_t pc;
    word_t ir;
  } fq_entry_t;
endpackage

// File: rtl/stage_fetch_queue_if.sv
// stage_fetch_queue_if: instruction memory, redirect and decode-side signals of the fetch stage
interface stage_fetch_queue_if import stage_fetch_queue_pkg::*; #(
  parameter int DEPTH = 4
);
  word_t                        imem_addr_o;
  logic                         imem_req_o;
  word_t                        imem_data_i;
  word_t                        jmp_addr_i;
  logic                         jmp_valid_i;
  logic                         halt_i;
  logic                         ready_i;
  logic                         valid_o;
  word_t                        pc_o;
  word_t                        ir_o;
  word_t                        pc_next_o;
  logic [$clog2(DEPTH+1)-1:0]   level_o;
  modport master (
    input  imem_data_i, jmp_addr_i, jmp_valid_i, halt_i, ready_i,
    output imem_addr_o, imem_req_o, valid_o, pc_o, ir_o, pc_next_o, level_o
  );
  modport slave (
    output imem_data_i, jmp_addr_i, jmp_valid_i, halt_i, ready_i,
    input  imem_addr_o, imem_req_o, valid_o, pc_o, ir_o, pc_next_o, level_o
  );
endinterface

// File: rtl/stage_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with dominant flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_pop, w_push;
  assign w_pop  = pop_i && r_cnt != '0;
  assign w_push = push_i && (r_cnt != CW'(DEPTH) || w_pop);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop);
      r_wr  <= r_wr + AW'(w_push);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push && !flush_i) r_mem[r_wr] <= data_i;
  assign data_o  = r_mem[r_rd];
  assign count_o = r_cnt;
endmodule

// File: rtl/stage_fetch_queue.sv
// stage_fetch_queue: instruction fetch with credit-limited issue into a prefetch queue toward decode
module stage_fetch_queue import stage_fetch_queue_pkg::*; #(
  parameter int    DEPTH        = 4,
  parameter int    MEM_LATENCY  = 1,
  parameter word_t RESET_VECTOR = 32'h0000_0000
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  stage_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  word_t                  r_pc;
  logic [MEM_LATENCY-1:0] r_infl_v;
  word_t                  r_infl_pc [MEM_LATENCY];
  logic [CW-1:0]          w_level;
  logic                   w_req, w_land, w_pop, w_valid;
  fq_entry_t              w_head;
  word_t                  w_pc;
  // the slot landing this cycle still holds its credit, so a push never meets a full queue
  assign w_req   = rst_ni && !bus.halt_i && !bus.jmp_valid_i &&
                   (int'(w_level) + $countones(r_infl_v) < DEPTH);
  assign w_land  = r_infl_v[MEM_LATENCY-1];
  assign w_valid = w_level != '0;
  assign w_pop   = w_valid && bus.ready_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_pc     <= RESET_VECTOR;
      r_infl_v <= '0;
    end else begin
      r_pc     <= bus.jmp_valid_i ? bus.jmp_addr_i : w_req ? r_pc + 32'd4 : r_pc;
      r_infl_v <= bus.jmp_valid_i ? '0 : (r_infl_v << 1) | MEM_LATENCY'(w_req);
    end
  always_ff @(posedge clk_i) begin
    r_infl_pc[0] <= r_pc;
    for (int k = 1; k < MEM_LATENCY; k++) r_infl_pc[k] <= r_infl_pc[k-1];
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fq_entry_t))) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_land),
    .pop_i   (w_pop),
    .flush_i (bus.jmp_valid_i),
    .data_i  ({r_infl_pc[MEM_LATENCY-1], bus.imem_data_i}),
    .data_o  (w_head),
    .count_o (w_level)
  );
  assign w_pc            = w_valid ? w_head.pc : '0;
  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_pc;
  assign bus.valid_o     = w_valid;
  assign bus.pc_o        = w_pc;
  assign bus.ir_o        = w_valid ? w_head.ir : NOP_INSTR;
  assign bus.pc_next_o   = w_pc + 32'd4;
  assign bus.level_o     = w_level;
endmodule

// File: tb/tb_stage_fetch_queue.sv
// tb_stage_fetch_queue: checks two fetch stages (latency 1 and 3, depth 4) against a queue-based reference model
module tb_stage_fetch_queue;
  import stage_fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  halt = 1'b0, jmp = 1'b0, ready = 1'b1;
  word_t jaddr = '0;
  word_t data [2];
  int    errors = 0, checks = 0;
  int    nreq [2];
  int    s0, s1;
  word_t mq [2][$];
  word_t mfp [2][$];
  int    mdue [2][$];
  word_t hist [2][$];
  word_t mpc [2];
  int    mcyc = 0;

  always #5 clk = ~clk;

  stage_fetch_queue_if #(.DEPTH(DEPTH)) b0 ();
  stage_fetch_queue_if #(.DEPTH(DEPTH)) b1 ();
  stage_fetch_queue #(.DEPTH(DEPTH), .MEM_LATENCY(1), .RESET_VECTOR(32'h0)) d0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  stage_fetch_queue #(.DEPTH(DEPTH), .MEM_LATENCY(3), .RESET_VECTOR(32'h0)) d1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));
  assign b0.halt_i = halt;  assign b1.halt_i = halt;
  assign b0.jmp_valid_i = jmp;  assign b1.jmp_valid_i = jmp;
  assign b0.jmp_addr_i = jaddr;  assign b1.jmp_addr_i = jaddr;
  assign b0.ready_i = ready;  assign b1.ready_i = ready;
  assign b0.imem_data_i = data[0];  assign b1.imem_data_i = data[1];

  function automatic int lat(input int g);
    return g == 0 ? 1 : 3;
  endfunction

  function automatic word_t memfn(input word_t a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      mq[g].delete(); mfp[g].delete(); mdue[g].delete();
      mpc[g] = 32'h0;
    end
  endtask

  // one clock edge of the reference: land, pop, redirect and issue by the stage's rules
  task automatic model_step();
    if (rst_n) begin
      for (int g = 0; g < 2; g++) begin
        bit    req, land, pop;
        word_t lpc;
        req  = !halt && !jmp && (mq[g].size() + mfp[g].size() < DEPTH);
        land = mfp[g].size() > 0 && mdue[g][0] == mcyc;
        pop  = mq[g].size() > 0 && ready;
        lpc  = '0;
        if (land) begin lpc = mfp[g].pop_front(); void'(mdue[g].pop_front()); end
        if (jmp) begin
          mq[g].delete(); mfp[g].delete(); mdue[g].delete();
          mpc[g] = jaddr;
        end else begin
          if (pop) void'(mq[g].pop_front());
          if (land) mq[g].push_back(lpc);
          if (req) begin mfp[g].push_back(mpc[g]); mdue[g].push_back(mcyc + lat(g)); mpc[g] += 32'd4; end
        end
      end
    end
    mcyc++;
  endtask

  task automatic chk_dut(input int g, input string n, input logic req, input word_t addr, input logic valid,
                         input word_t pc, input word_t ir, input word_t pcn, input logic [2:0] lvl);
    int    sz;
    bit    ev;
    word_t ep;
    sz = mq[g].size();
    ev = sz > 0;
    ep = ev ? mq[g][0] : 32'h0;
    cmp({n, ".req"}, 32'(req), 32'(rst_n && !halt && !jmp && (sz + mfp[g].size() < DEPTH)));
    cmp({n, ".addr"}, addr, mpc[g]);
    cmp({n, ".valid"}, 32'(valid), 32'(ev));
    cmp({n, ".pc"}, pc, ep);
    cmp({n, ".ir"}, ir, ev ? memfn(ep) : NOP_INSTR);
    cmp({n, ".pc_next"}, pcn, ep + 32'd4);
    cmp({n, ".level"}, 32'(lvl), sz);
    if (req === 1'b1) nreq[g]++;
    hist[g].push_back(req === 1'b1 ? memfn(addr) : $urandom);
    if (hist[g].size() > 4) void'(hist[g].pop_front());
  endtask

  task automatic rst_vals(input string n, input logic req, input word_t addr, input logic valid,
                          input word_t pc, input word_t ir, input word_t pcn, input logic [2:0] lvl);
    cmp({n, ".req"}, 32'(req), 0);
    cmp({n, ".addr"}, addr, 32'h0);
    cmp({n, ".valid"}, 32'(valid), 0);
    cmp({n, ".pc"}, pc, 32'h0);
    cmp({n, ".ir"}, ir, 32'h0000_0013);
    cmp({n, ".pc_next"}, pcn, 32'h4);
    cmp({n, ".level"}, 32'(lvl), 0);
  endtask

  task automatic sample();
    @(negedge clk);
    chk_dut(0, "d0", b0.imem_req_o, b0.imem_addr_o, b0.valid_o, b0.pc_o, b0.ir_o, b0.pc_next_o, b0.level_o);
    chk_dut(1, "d1", b1.imem_req_o, b1.imem_addr_o, b1.valid_o, b1.pc_o, b1.ir_o, b1.pc_next_o, b1.level_o);
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
    model_step();
    for (int g = 0; g < 2; g++)
      data[g] = hist[g].size() >= lat(g) ? hist[g][hist[g].size() - lat(g)] : $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) begin sample(); adv(); end
  endtask

  // reset lands mid-cycle; outputs must respond before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_vals("rst0", b0.imem_req_o, b0.imem_addr_o, b0.valid_o, b0.pc_o, b0.ir_o, b0.pc_next_o, b0.level_o);
    rst_vals("rst1", b1.imem_req_o, b1.imem_addr_o, b1.valid_o, b1.pc_o, b1.ir_o, b1.pc_next_o, b1.level_o);
    sample(); adv();
    rst_n = 1'b1;
  endtask

  initial begin
    nreq[0] = 0; nreq[1] = 0;
    #3;
    do_reset();
    sample(); cmp("a.req0", 32'(b0.imem_req_o), 1); cmp("a.addr0", b0.imem_addr_o, 32'h0); adv();
    sample(); cmp("a.addr1", b0.imem_addr_o, 32'h4); cmp("a.valid1", 32'(b0.valid_o), 0); adv();
    sample(); cmp("a.addr2", b0.imem_addr_o, 32'h8); cmp("a.valid2", 32'(b0.valid_o), 1); cmp("a.pc2", b0.pc_o, 32'h0); adv();
    sample(); cmp("a.pc3", b0.pc_o, 32'h4); adv();
    run(5);
    ready = 1'b0;
    do_reset();
    s1 = nreq[1];
    run(12);
    sample();
    cmp("b.level", 32'(b1.level_o), 4); cmp("b.req", 32'(b1.imem_req_o), 0);
    cmp("b.nreq", nreq[1] - s1, 4); cmp("b.level_d0", 32'(b0.level_o), 4);
    adv();
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      cmp("b.pop_pc", b1.pc_o, 32'(4 * k));
      cmp("b.resume", 32'(b1.imem_req_o), 32'(k > 0));
      adv();
    end
    run(4);
    do_reset();
    run(3);
    jmp = 1'b1; jaddr = 32'h100;
    sample(); cmp("c.req_on_jmp", 32'(b1.imem_req_o), 0); adv();
    jmp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      cmp("c.no_stale", 32'(b1.valid_o), 0);
      if (i == 0) cmp("c.target_addr", b1.imem_addr_o, 32'h100);
      adv();
    end
    sample(); cmp("c.valid", 32'(b1.valid_o), 1); cmp("c.pc", b1.pc_o, 32'h100); adv();
    run(4);
    jmp = 1'b1; jaddr = 32'h200;
    sample(); cmp("d.pre_valid", 32'(b0.valid_o), 1); adv();
    jmp = 1'b0;
    sample(); cmp("d.level", 32'(b0.level_o), 0); cmp("d.valid", 32'(b0.valid_o), 0); adv();
    run(6);
    ready = 1'b0;
    do_reset();
    s0 = nreq[1];
    run(2);
    halt = 1'b1;
    run(6);
    sample(); cmp("e.level", 32'(b1.level_o), 2); cmp("e.nreq", nreq[1] - s0, 2); cmp("e.req", 32'(b1.imem_req_o), 0); adv();
    ready = 1'b1;
    run(3);
    sample(); cmp("e.drained", 32'(b1.level_o), 0); adv();
    jmp = 1'b1; jaddr = 32'h40;
    run(1);
    jmp = 1'b0;
    run(2);
    halt = 1'b0;
    sample(); cmp("e.req_after", 32'(b1.imem_req_o), 1); cmp("e.addr_after", b1.imem_addr_o, 32'h40); adv();
    run(6);
    jmp = 1'b1; jaddr = 32'hFFFF_FFF8;
    run(1);
    jmp = 1'b0;
    run(10);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      halt  = $urandom_range(7) == 0;
      jmp   = $urandom_range(15) == 0;
      jaddr = $urandom_range(3) == 0 ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      ready = $urandom_range(3) != 0;
      sample(); adv();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
